mlp_neuron_unit: RTL and testbench
==================================

Name: mlp_neuron_unit

Overview:
- Single configurable neuron for the fixed-point XOR MLP (2 inputs -> 2 hidden ReLU neurons -> 1 linear output neuron).
- Covers both roles:
  - hidden role: binary inputs, ReLU activation;
  - output role: Q3.12 inputs, linear activation.
- Computes bias plus the weighted sum, applies saturation and activation, and registers the result with a valid flag. The network top instantiates three copies.

Parameters:
- NUM_INPUTS, 2, number of inputs and weights (1..8).
- DATA_WIDTH, 16, signed word width of weights, bias, data inputs and output.
- FRAC_BITS, 12, fractional bits (Q3.12 at defaults).
- BINARY_INPUTS, 1, 1 = inputs are 1-bit (x_bits); 0 = inputs are signed fixed-point words (x_data).
- RELU, 1, 1 = ReLU activation; 0 = linear (identity).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; sampled on the clk edge.
- x_bits  input  NUM_INPUTS  binary inputs, bit i = input i; ignored when BINARY_INPUTS=0.
- x_data  input  NUM_INPUTS*DATA_WIDTH  signed Q inputs, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]; ignored when BINARY_INPUTS=1.
- weights  input  NUM_INPUTS*DATA_WIDTH  signed Q weights, lane i pairs with input i.
- bias  input  DATA_WIDTH  signed Q bias.
- out_valid  output  1  neuron_out holds a new result.
- neuron_out  output  DATA_WIDTH  signed Q result after activation.

Behaviour:
- Reset:
  - rst_n low asynchronously forces out_valid=0 and neuron_out=0.
  - Reset asserted mid-operation discards any in-flight result.
  - The first valid result appears no earlier than the first in_valid edge after rst_n rises.
- Latency: 1 cycle.
  - in_valid=1 at edge N -> out_valid=1 and neuron_out=result after edge N.
  - No back-pressure; a new operand set may be presented every cycle.
  - in_valid=0 at an edge -> out_valid=0 and neuron_out holds its previous value.
- Accumulator:
  - Signed, width 2*DATA_WIDTH + clog2(NUM_INPUTS) + 1.
  - Initialised to the sign-extended bias.
- Binary mode (BINARY_INPUTS=1):
  - term_i = weights[i] if x_bits[i]=1, else 0.
  - No multiply and no shift.
- Fixed-point mode (BINARY_INPUTS=0):
  - product_i = x_data[i] * weights[i], full 2*DATA_WIDTH signed.
  - term_i = product_i >>> FRAC_BITS (arithmetic shift, floor toward -inf, no rounding).
- sum = bias + sum of all term_i, computed without intermediate overflow.
- Saturation: clamp sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. 0x8000..0x7FFF at defaults.
- Activation (applied after saturation):
  - RELU=1: negative -> 0, otherwise unchanged.
  - RELU=0: unchanged.
- Fully combinational datapath feeding a single output register; no internal state other than out_valid and neuron_out.
- Weights and bias are treated as quasi-static but are sampled with the inputs on each in_valid edge.
- X/Z on ignored input ports must not affect the output.

Test Plan:
- Reset:
  - Setup: rst_n low with in_valid=1 and arbitrary operands.
  - Required: out_valid=0, neuron_out=0x0000, including when reset is asserted between edges mid-stream.
  - Then release rst_n and apply one valid cycle -> out_valid pulses for exactly one cycle.
- Hidden role (BINARY_INPUTS=1, RELU=1):
  - Setup: weights {0x1000, 0x1000}, bias 0xF000.
  - Required: x_bits 00 -> 0x0000; 01 -> 0x0000; 10 -> 0x0000; 11 -> 0x1000. Each result appears one cycle after in_valid.
- ReLU clamp, same hidden setup:
  - Setup: bias 0xE800, x_bits 01.
  - Required: 0x0000.
  - The same case with RELU=0 -> 0xF800.
- Output role (BINARY_INPUTS=0, RELU=0):
  - Setup: x_data {0x1000, 0x0000}, weights {0x2000, 0xE000}, bias 0x0000.
  - Required: 0x2000.
  - x_data {0x1000, 0x1000} -> 0x0000.
- Floor and sign behaviour, output role:
  - Setup: x_data {0x0001, 0x0000}, weights {0xFFFF, 0}, bias 0.
  - Required: 0xFFFF (floor of -2^-24 is -1 LSB).
- Saturation, output role:
  - Setup: all x_data, weights and bias 0x7FFF.
  - Required: 0x7FFF.
  - x_data 0x7FFF, weights 0x8000, bias 0x8000 -> 0x8000.
  - Back-to-back in_valid every cycle with alternating operand sets -> each result appears on the following cycle with no drops.

Source files
------------

// File: rtl/mlp_neuron_unit.sv
// mlp_neuron_unit
//   Single configurable neuron for the fixed-point XOR MLP. The bias is added
//   to the weighted sum of the inputs. The sum is saturated to DATA_WIDTH,
//   the activation is applied, and the result is registered with a valid
//   flag one cycle after in_valid.
//
// Parameters:
//   NUM_INPUTS    number of inputs / weights (1..8)
//   DATA_WIDTH    signed word width of weights, bias, x_data and output
//   FRAC_BITS     fractional bits of the Q format
//   BINARY_INPUTS 1: inputs come from x_bits (weight gating, no multiply)
//                 0: inputs come from x_data (Q multiply, arithmetic shift)
//   RELU          1: ReLU activation, 0: identity
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid this cycle
//   x_bits     binary inputs, bit i = input i (binary mode only)
//   x_data     signed Q inputs, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   weights    signed Q weights, lane i pairs with input i
//   bias       signed Q bias
//   out_valid  neuron_out holds a new result
//   neuron_out signed Q result after activation
module mlp_neuron_unit #(
    parameter int NUM_INPUTS    = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int FRAC_BITS     = 12,
    parameter int BINARY_INPUTS = 1,
    parameter int RELU          = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [NUM_INPUTS-1:0]            x_bits,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] x_data,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] weights,
    input  logic [DATA_WIDTH-1:0]            bias,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            neuron_out
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(NUM_INPUTS) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0]      acc;
    logic        [DATA_WIDTH-1:0] sat;
    logic        [DATA_WIDTH-1:0] act;

    // Only the selected input port reaches the accumulator, so X/Z on the
    // ignored port cannot propagate to the output.
    generate
        if (BINARY_INPUTS != 0) begin : g_binary
            logic unused_x_data;
            assign unused_x_data = ^{1'b0, x_data};

            always_comb begin
                logic [DATA_WIDTH-1:0] w;
                w   = '0;
                acc = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    w = weights[i*DATA_WIDTH +: DATA_WIDTH];
                    if (x_bits[i]) begin
                        acc = acc + {{(ACC_W-DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
                    end
                end
            end
        end else begin : g_fixed
            logic unused_x_bits;
            assign unused_x_bits = ^{1'b0, x_bits};

            always_comb begin
                logic signed [DATA_WIDTH-1:0] xa;
                logic signed [DATA_WIDTH-1:0] wa;
                logic signed [PROD_W-1:0]     prod;
                logic signed [PROD_W-1:0]     term;
                xa   = '0;
                wa   = '0;
                prod = '0;
                term = '0;
                acc  = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    xa   = x_data[i*DATA_WIDTH +: DATA_WIDTH];
                    wa   = weights[i*DATA_WIDTH +: DATA_WIDTH];
                    prod = xa * wa;
                    // Arithmetic shift floors toward -inf; no rounding.
                    term = prod >>> FRAC_BITS;
                    acc  = acc + {{(ACC_W-PROD_W){term[PROD_W-1]}}, term};
                end
            end
        end
    endgenerate

    always_comb begin
        sat = acc[DATA_WIDTH-1:0];
        if (acc > SAT_MAX) begin
            sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc < SAT_MIN) begin
            sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        act = sat;
        if ((RELU != 0) && sat[DATA_WIDTH-1]) begin
            act = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            neuron_out <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                neuron_out <= act;
            end
        end
    end

endmodule

// File: tb/tb_mlp_neuron_unit.sv
// Testbench for mlp_neuron_unit: three instances (hidden ReLU, hidden linear,
// output linear) share the operand buses; each vector names the instance whose
// result it checks.
module tb_mlp_neuron_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  x_bits = '0;
    logic [31:0] x_data = '0;
    logic [31:0] weights = '0;
    logic [15:0] bias = '0;

    logic        ov_hid, ov_lin, ov_out;
    logic [15:0] no_hid, no_lin, no_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mlp_neuron_unit #(.NUM_INPUTS(2), .DATA_WIDTH(16), .FRAC_BITS(12),
                      .BINARY_INPUTS(1), .RELU(1)) u_hid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_bits(x_bits),
        .x_data(x_data), .weights(weights), .bias(bias),
        .out_valid(ov_hid), .neuron_out(no_hid));

    mlp_neuron_unit #(.NUM_INPUTS(2), .DATA_WIDTH(16), .FRAC_BITS(12),
                      .BINARY_INPUTS(1), .RELU(0)) u_lin (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_bits(x_bits),
        .x_data(x_data), .weights(weights), .bias(bias),
        .out_valid(ov_lin), .neuron_out(no_lin));

    mlp_neuron_unit #(.NUM_INPUTS(2), .DATA_WIDTH(16), .FRAC_BITS(12),
                      .BINARY_INPUTS(0), .RELU(0)) u_out (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_bits(x_bits),
        .x_data(x_data), .weights(weights), .bias(bias),
        .out_valid(ov_out), .neuron_out(no_out));

    typedef struct {
        logic [1:0]  xb;
        logic [31:0] xd;
        logic [31:0] w;
        logic [15:0] b;
        int          dut;   // 0 = u_hid, 1 = u_lin, 2 = u_out
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_all_reset(input string name);
        check({name, "_hid_v"}, {15'd0, ov_hid}, 16'h0000);
        check({name, "_hid_o"}, no_hid, 16'h0000);
        check({name, "_lin_v"}, {15'd0, ov_lin}, 16'h0000);
        check({name, "_lin_o"}, no_lin, 16'h0000);
        check({name, "_out_v"}, {15'd0, ov_out}, 16'h0000);
        check({name, "_out_o"}, no_out, 16'h0000);
    endtask

    initial begin
        logic        gv;
        logic [15:0] go;

        // Hidden role: weights {0x1000,0x1000}, bias 0xF000
        vecs[0]  = '{2'b00, 32'h0, 32'h1000_1000, 16'hF000, 0, 16'h0000};
        vecs[1]  = '{2'b01, 32'h0, 32'h1000_1000, 16'hF000, 0, 16'h0000};
        vecs[2]  = '{2'b10, 32'h0, 32'h1000_1000, 16'hF000, 0, 16'h0000};
        vecs[3]  = '{2'b11, 32'h0, 32'h1000_1000, 16'hF000, 0, 16'h1000};
        // ReLU clamp and its linear twin
        vecs[4]  = '{2'b01, 32'h0, 32'h1000_1000, 16'hE800, 0, 16'h0000};
        vecs[5]  = '{2'b01, 32'h0, 32'h1000_1000, 16'hE800, 1, 16'hF800};
        // Output role
        vecs[6]  = '{2'b00, 32'h0000_1000, 32'hE000_2000, 16'h0000, 2, 16'h2000};
        vecs[7]  = '{2'b00, 32'h1000_1000, 32'hE000_2000, 16'h0000, 2, 16'h0000};
        // Floor: -2^-24 -> -1 LSB; -1.5 LSB -> -2 LSB
        vecs[8]  = '{2'b00, 32'h0000_0001, 32'h0000_FFFF, 16'h0000, 2, 16'hFFFF};
        vecs[9]  = '{2'b00, 32'h0000_0003, 32'h0000_F800, 16'h0000, 2, 16'hFFFE};
        // Saturation high and low
        vecs[10] = '{2'b00, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 16'h7FFF, 2, 16'h7FFF};
        vecs[11] = '{2'b00, 32'h7FFF_7FFF, 32'h8000_8000, 16'h8000, 2, 16'h8000};

        // Reset held with live operands
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x_bits   = 2'b11;
        x_data   = 32'h7FFF_7FFF;
        weights  = 32'h1000_1000;
        bias     = 16'h0100;
        repeat (3) @(posedge clk);
        #1 check_all_reset("rst_hold");

        // Release, one valid cycle -> single-cycle pulse
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 check("rel_idle_v", {15'd0, ov_hid}, 16'h0000);
        @(negedge clk);
        in_valid = 1'b1;
        bias     = 16'hF000;
        @(posedge clk);
        #1 check("pulse_v", {15'd0, ov_hid}, 16'h0001);
        check("pulse_o", no_hid, 16'h1000);
        @(negedge clk);
        in_valid = 1'b0;
        x_bits   = 2'b00;
        @(posedge clk);
        #1 check("pulse_end_v", {15'd0, ov_hid}, 16'h0000);
        check("hold_o", no_hid, 16'h1000);

        // Table vectors, back-to-back with in_valid high every cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_bits   = vecs[i].xb;
            x_data   = vecs[i].xd;
            weights  = vecs[i].w;
            bias     = vecs[i].b;
            @(posedge clk);
            #1;
            case (vecs[i].dut)
                0:       begin gv = ov_hid; go = no_hid; end
                1:       begin gv = ov_lin; go = no_lin; end
                default: begin gv = ov_out; go = no_out; end
            endcase
            check($sformatf("vec%0d_v", i), {15'd0, gv}, 16'h0001);
            check($sformatf("vec%0d_o", i), go, vecs[i].exp);
        end

        // Ignored ports carrying X must not disturb the result
        @(negedge clk);
        x_bits  = 2'b11;
        x_data  = 'x;
        weights = 32'h1000_1000;
        bias    = 16'hF000;
        @(posedge clk);
        #1 check("xdata_x_hid", no_hid, 16'h1000);
        @(negedge clk);
        x_bits  = 'x;
        x_data  = 32'h0000_1000;
        weights = 32'hE000_2000;
        bias    = 16'h0000;
        @(posedge clk);
        #1 check("xbits_x_out", no_out, 16'h2000);

        // Asynchronous reset mid-stream, between edges
        @(negedge clk);
        x_bits = 2'b11;
        x_data = 32'h1000_1000;
        #2 rst_n = 1'b0;
        #1 check_all_reset("rst_async");
        @(posedge clk);
        #1 check_all_reset("rst_mid_edge");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 check("post_rst_v", {15'd0, ov_hid}, 16'h0000);
        check("post_rst_o", no_hid, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
